// File: rtl/multiply_seq.sv
// multiply_seq: multi-cycle shift-add multiplier, unsigned or two's-complement
// signed, with a start/busy/done handshake and a result held between operations.
module multiply_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      acc_d;
    logic [PW-1:0]      out_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1) as an unsigned WIDTH-bit value.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (signed_mode && a[WIDTH-1]) begin
            mag_a = WIDTH'(-a);
        end
        if (signed_mode && b[WIDTH-1]) begin
            mag_b = WIDTH'(-b);
        end
    end

    // One shift-add step: the low half of acc holds the remaining multiplier bits.
    always_comb begin
        sum   = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end

    // Control FSM with datapath registers; reset has priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sign_q  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand_q <= mag_a;
                        acc_q   <= {{WIDTH{1'b0}}, mag_b};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final iteration: the sign is applied to the just-computed accumulator.
                    if (cnt_q >= CW'(WIDTH - 1)) begin
                        out_q   <= sign_q ? PW'(-acc_d) : acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
